// File: rtl/spi_host_rx_shifter.sv
// SPI Host receive shifter: deserialises sampled SD lines (std/dual/quad)
// into MSB-first bytes and hands them off on a valid/ready byte interface.
// A completed byte that cannot be handed off is parked in the shift
// register and raises stall_o so the timing FSM pauses sampling.
module spi_host_rx_shifter #(
    parameter int ByteCntW = 9
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sw_rst_i,
    input  logic                start_i,
    input  logic [ByteCntW-1:0] len_i,
    input  logic [1:0]          speed_i,
    input  logic                sample_i,
    input  logic [3:0]          sd_i,
    output logic [7:0]          byte_o,
    output logic                byte_last_o,
    output logic                byte_valid_o,
    input  logic                byte_ready_i,
    output logic                stall_o,
    output logic                busy_o,
    output logic                overrun_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_reg;
    logic [ByteCntW-1:0] len_reg;
    logic [ByteCntW-1:0] byte_cnt_reg;
    logic [1:0]          speed_reg;
    logic [2:0]          bit_cnt_reg;
    logic [7:0]          shreg_reg;
    logic [7:0]          byte_reg;
    logic                last_reg;
    logic                valid_reg;
    logic                stall_reg;     // doubles as the "byte pending in shreg" flag
    logic                pend_last_reg;
    logic                overrun_reg;

    logic [7:0]          shift_next;
    logic [3:0]          bps;
    logic [3:0]          bit_sum;
    logic                byte_done;
    logic                is_last;
    logic                out_free;
    logic                accept;

    // Per-mode bit extraction: std uses sd[1] only, dual sd[1:0], quad sd[3:0]
    always_comb begin
        shift_next = {shreg_reg[6:0], sd_i[1]};
        bps        = 4'd1;
        case (speed_reg)
            2'd1: begin
                shift_next = {shreg_reg[5:0], sd_i[1:0]};
                bps        = 4'd2;
            end
            2'd2: begin
                shift_next = {shreg_reg[3:0], sd_i[3:0]};
                bps        = 4'd4;
            end
            default: ;
        endcase
    end

    // The bit counter only ever holds multiples of bps, so the sum never exceeds 8
    assign bit_sum   = {1'b0, bit_cnt_reg} + bps;
    assign byte_done = (bit_sum == 4'd8);
    assign is_last   = (byte_cnt_reg == len_reg);
    assign accept    = valid_reg & byte_ready_i;
    assign out_free  = ~valid_reg | byte_ready_i;

    // Main state machine, shift register and output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            byte_cnt_reg  <= '0;
            speed_reg     <= 2'd0;
            bit_cnt_reg   <= 3'd0;
            shreg_reg     <= 8'd0;
            byte_reg      <= 8'd0;
            last_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            stall_reg     <= 1'b0;
            pend_last_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else if (sw_rst_i) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            byte_cnt_reg  <= '0;
            speed_reg     <= 2'd0;
            bit_cnt_reg   <= 3'd0;
            shreg_reg     <= 8'd0;
            byte_reg      <= 8'd0;
            last_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            stall_reg     <= 1'b0;
            pend_last_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            // Output hand-off: an accepted byte is replaced by the pending one, if any
            if (accept) begin
                if (stall_reg) begin
                    byte_reg  <= shreg_reg;
                    last_reg  <= pend_last_reg;
                    stall_reg <= 1'b0;
                end else begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        state_reg    <= ST_SHIFT;
                        len_reg      <= len_i;
                        speed_reg    <= speed_i;
                        bit_cnt_reg  <= 3'd0;
                        byte_cnt_reg <= '0;
                        overrun_reg  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (sample_i) begin
                        if (stall_reg) begin
                            overrun_reg <= 1'b1;
                        end else begin
                            shreg_reg <= shift_next;
                            if (byte_done) begin
                                bit_cnt_reg <= 3'd0;
                                if (out_free) begin
                                    byte_reg  <= shift_next;
                                    valid_reg <= 1'b1;
                                    last_reg  <= is_last;
                                end else begin
                                    stall_reg     <= 1'b1;
                                    pend_last_reg <= is_last;
                                end
                                if (is_last) begin
                                    state_reg <= ST_DRAIN;
                                end else begin
                                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                                end
                            end else begin
                                bit_cnt_reg <= bit_sum[2:0];
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once the output register empties with nothing pending
                    if (out_free && !stall_reg) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign byte_o       = byte_reg;
    assign byte_last_o  = last_reg;
    assign byte_valid_o = valid_reg;
    assign stall_o      = stall_reg;
    assign overrun_o    = overrun_reg;
    assign busy_o       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_spi_host_rx_shifter.sv
// Bench for spi_host_rx_shifter: directed scenarios plus randomized segments
// checked against a bit-stream reference model.
module tb_spi_host_rx_shifter;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       sw_rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic [8:0] len_i = '0;
    logic [1:0] speed_i = 2'd0;
    logic       sample_i = 1'b0;
    logic [3:0] sd_i = 4'd0;
    logic [7:0] byte_o;
    logic       byte_last_o;
    logic       byte_valid_o;
    logic       byte_ready_i = 1'b0;
    logic       stall_o;
    logic       busy_o;
    logic       overrun_o;

    int total = 0;
    int bad = 0;
    bit rand_ready = 0;

    logic [3:0] samp_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    spi_host_rx_shifter #(.ByteCntW(9)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sw_rst_i     (sw_rst_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .speed_i      (speed_i),
        .sample_i     (sample_i),
        .sd_i         (sd_i),
        .byte_o       (byte_o),
        .byte_last_o  (byte_last_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every completed hand-off, sampled mid-cycle
    always @(negedge clk_i) begin
        if (byte_valid_o && byte_ready_i) begin
            got_q.push_back({byte_last_o, byte_o});
            $display("xfer byte=0x%02h last=%0d", byte_o, byte_last_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_ready) byte_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic sample_cycle(input logic [3:0] sd);
        sample_i = 1'b1;
        sd_i     = sd;
        tick();
        sample_i = 1'b0;
    endtask

    task automatic start_seg(input int len, input int spd);
        start_i = 1'b1;
        len_i   = 9'(len);
        speed_i = 2'(spd);
        tick();
        start_i = 1'b0;
    endtask

    // Std mode carries one bit on sd[1]; send a byte MSB first
    task automatic std_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sample_cycle({2'b00, b[i], 1'b0});
            samp_q.push_back({2'b00, b[i], 1'b0});
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy_o; i++) tick();
        check("idle_timeout", busy_o, 0);
    endtask

    // Reference model: concatenate the per-sample bits of the mode into a
    // continuous MSB-first stream and cut it every 8 bits; index len is last
    task automatic model(input int spd, input int len);
        int acc, nb, w, idx;
        logic [3:0] s;
        int v;
        acc = 0; nb = 0; idx = 0;
        w = (spd == 1) ? 2 : (spd == 2) ? 4 : 1;
        exp_q.delete();
        foreach (samp_q[i]) begin
            s = samp_q[i];
            v = (w == 1) ? int'(s[1]) : (w == 2) ? int'(s[1:0]) : int'(s);
            acc = acc * (1 << w) + v;
            nb += w;
            if (nb == 8) begin
                exp_q.push_back({(idx == len), 8'(acc)});
                idx++;
                acc = 0;
                nb = 0;
            end
        end
    endtask

    task automatic compare_q(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_valid", byte_valid_o, 0);
        check("rst_byte", byte_o, 0);
        check("rst_last", byte_last_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overrun", overrun_o, 0);
        rst_i = 1'b0;
        tick();

        // Std, len=1, two bytes, ready high, latency 1 from 8th sample
        byte_ready_i = 1'b1;
        got_q.delete(); samp_q.delete();
        start_seg(1, 0);
        check("t1_busy", busy_o, 1);
        begin
            logic [7:0] b0 = 8'hA5;
            for (int i = 7; i >= 1; i--) sample_cycle({2'b00, b0[i], 1'b0});
            check("t1_valid_early", byte_valid_o, 0);
            sample_cycle({2'b00, b0[0], 1'b0});
        end
        check("t1_valid0", byte_valid_o, 1);
        check("t1_byte0", byte_o, 8'hA5);
        check("t1_last0", byte_last_o, 0);
        sample_cycle(4'hF);
        check("t1_accepted", byte_valid_o, 0);
        for (int i = 0; i < 7; i++) sample_cycle(4'hF);
        check("t1_valid1", byte_valid_o, 1);
        check("t1_byte1", byte_o, 8'hFF);
        check("t1_last1", byte_last_o, 1);
        check("t1_busy_drain", busy_o, 1);
        tick();
        check("t1_done_valid", byte_valid_o, 0);
        check("t1_done_busy", busy_o, 0);

        // Quad, len=3
        got_q.delete(); samp_q.delete();
        start_seg(3, 2);
        begin
            logic [3:0] qs[8] = '{4'hA, 4'h5, 4'h3, 4'hC, 4'h0, 4'hF, 4'h1, 4'h2};
            foreach (qs[i]) begin
                sample_cycle(qs[i]);
                samp_q.push_back(qs[i]);
            end
        end
        wait_idle();
        model(2, 3);
        check("t2_exp_last", exp_q[3], {1'b1, 8'h12});
        compare_q("t2");

        // Dual, ready low through two bytes -> pending byte and stall
        byte_ready_i = 1'b0;
        got_q.delete(); samp_q.delete();
        start_seg(3, 1);
        begin
            logic [3:0] ds[8] = '{4'd2, 4'd1, 4'd3, 4'd0, 4'd0, 4'd3, 4'd1, 4'd2};
            foreach (ds[i]) begin
                sample_cycle(ds[i]);
                samp_q.push_back(ds[i]);
                if (i == 3) begin
                    check("t3_valid0", byte_valid_o, 1);
                    check("t3_byte0", byte_o, 8'h9C);
                end
            end
        end
        check("t3_stall", stall_o, 1);
        check("t3_hold_byte", byte_o, 8'h9C);
        sample_cycle(4'd3);
        check("t3_overrun", overrun_o, 1);
        check("t3_stall_still", stall_o, 1);
        byte_ready_i = 1'b1;
        tick();
        check("t3_b2b_valid", byte_valid_o, 1);
        check("t3_b2b_byte", byte_o, 8'h36);
        check("t3_unstall", stall_o, 0);
        tick();
        check("t3_drained", byte_valid_o, 0);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] s = 4'($urandom_range(0, 15));
            sample_cycle(s);
            samp_q.push_back(s);
        end
        wait_idle();
        model(1, 3);
        compare_q("t3");
        check("t3_overrun_sticky", overrun_o, 1);

        // len=0, extra sample in DRAIN ignored
        byte_ready_i = 1'b0;
        start_seg(0, 0);
        check("t4_overrun_cleared", overrun_o, 0);
        std_byte(8'hC3);
        check("t4_valid", byte_valid_o, 1);
        check("t4_byte", byte_o, 8'hC3);
        check("t4_last", byte_last_o, 1);
        sample_cycle(4'hF);
        check("t4_overrun", overrun_o, 0);
        check("t4_byte_hold", byte_o, 8'hC3);
        check("t4_busy", busy_o, 1);
        byte_ready_i = 1'b1;
        tick();
        check("t4_valid_done", byte_valid_o, 0);
        check("t4_busy_done", busy_o, 0);

        // Async reset mid-byte with a held output byte
        byte_ready_i = 1'b0;
        start_seg(1, 0);
        std_byte(8'h3C);
        check("t5_valid", byte_valid_o, 1);
        for (int i = 0; i < 3; i++) sample_cycle(4'h2);
        #2 rst_i = 1'b1;
        #1;
        check("t5_rst_valid", byte_valid_o, 0);
        check("t5_rst_byte", byte_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_stall", stall_o, 0);
        tick();
        rst_i = 1'b0;
        byte_ready_i = 1'b1;
        got_q.delete(); samp_q.delete();
        start_seg(0, 0);
        std_byte(8'h96);
        wait_idle();
        model(0, 0);
        compare_q("t5");

        // sw_rst_i with start_i, start_i ignored in SHIFT, sw_rst mid-segment
        sw_rst_i = 1'b1; start_i = 1'b1; len_i = 9'd2;
        tick();
        sw_rst_i = 1'b0; start_i = 1'b0;
        check("t6_swrst_busy", busy_o, 0);
        tick();
        check("t6_stay_idle", busy_o, 0);
        start_seg(0, 0);
        check("t6_busy", busy_o, 1);
        start_seg(5, 2);
        std_byte(8'h5A);
        check("t6_valid", byte_valid_o, 1);
        check("t6_byte", byte_o, 8'h5A);
        check("t6_last", byte_last_o, 1);
        tick();
        check("t6_idle", busy_o, 0);
        byte_ready_i = 1'b0;
        start_seg(2, 0);
        std_byte(8'h81);
        check("t6_held", byte_valid_o, 1);
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        check("t6_sw_valid", byte_valid_o, 0);
        check("t6_sw_byte", byte_o, 0);
        check("t6_sw_busy", busy_o, 0);

        // Randomized segments with random back-pressure
        for (int seg = 0; seg < 12; seg++) begin
            int spd, len, spb, n, idx, budget;
            spd = $urandom_range(0, 3);
            len = $urandom_range(0, 4);
            spb = (spd == 1) ? 4 : (spd == 2) ? 2 : 8;
            n = (len + 1) * spb;
            samp_q.delete();
            for (int i = 0; i < n; i++) samp_q.push_back(4'($urandom_range(0, 15)));
            got_q.delete();
            rand_ready = 1;
            start_seg(len, spd);
            idx = 0;
            budget = 0;
            while (idx < n && budget < 2000) begin
                if (!stall_o && $urandom_range(0, 3) != 0) begin
                    sample_cycle(samp_q[idx]);
                    idx++;
                end else begin
                    tick();
                end
                budget++;
            end
            check("rnd_samples_sent", idx, n);
            wait_idle();
            rand_ready = 0;
            model(spd, len);
            compare_q("rnd");
            check("rnd_overrun", overrun_o, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
